// File: rtl/neuron_ctrl_if.sv
// Bundle between the layer scheduler, neuron_ctrl and the neuron MAC datapath.
// slave is the controller's view; master is the scheduler/datapath side.
interface neuron_ctrl_if;
    logic        start;
    logic [15:0] res;
    logic        rd_en;
    logic [15:0] idx;
    logic        acc_rst;
    logic        ld;
    logic        busy;
    logic        done;
    logic [15:0] result;

    modport master (
        output start,
        output res,
        input  rd_en,
        input  idx,
        input  acc_rst,
        input  ld,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  res,
        output rd_en,
        output idx,
        output acc_rst,
        output ld,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/neuron_ctrl.sv
// Sequences one neuron MAC datapath through an N-element dot product and
// captures the activation output once the accumulator holds the full sum.
module neuron_ctrl #(
    parameter int unsigned N = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    neuron_ctrl_if.slave bus
);
    // state     | meaning
    // S_IDLE    | waiting for start, all strobes low
    // S_CLEAR   | accumulator clear, first memory read (idx 0)
    // S_RUN     | N cycles of ld, reads run one element ahead
    // S_CAPTURE | latch datapath res into result
    // S_DONE    | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [16:0] N_W = 17'(N);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [15:0] idx_q;
    logic [15:0] result_q;
    logic        rd_en_q;
    logic        acc_rst_q;
    logic        ld_q;
    logic        busy_q;
    logic        done_q;

    // 17-bit so N=65535 cannot wrap the look-ahead compare
    logic [16:0] cnt_d;
    logic [16:0] idx_d;

    assign cnt_d = {1'b0, cnt_q} + 17'd1;
    assign idx_d = {1'b0, cnt_q} + 17'd2;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            result_q  <= '0;
            rd_en_q   <= 1'b0;
            acc_rst_q <= 1'b0;
            ld_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q   <= S_CLEAR;
                        cnt_q     <= '0;
                        acc_rst_q <= 1'b1;
                        rd_en_q   <= 1'b1;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state_q   <= S_RUN;
                    cnt_q     <= '0;
                    acc_rst_q <= 1'b0;
                    ld_q      <= 1'b1;
                    if (N_W > 17'd1) begin
                        rd_en_q <= 1'b1;
                        idx_q   <= 16'd1;
                    end else begin
                        rd_en_q <= 1'b0;
                        idx_q   <= '0;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_d[15:0];
                    if (cnt_d == N_W) begin
                        state_q <= S_CAPTURE;
                        ld_q    <= 1'b0;
                        rd_en_q <= 1'b0;
                        idx_q   <= '0;
                    end else begin
                        ld_q <= 1'b1;
                        if (idx_d < N_W) begin
                            rd_en_q <= 1'b1;
                            idx_q   <= idx_d[15:0];
                        end else begin
                            rd_en_q <= 1'b0;
                            idx_q   <= '0;
                        end
                    end
                end
                S_CAPTURE: begin
                    state_q  <= S_DONE;
                    result_q <= bus.res;
                    done_q   <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_en   = rd_en_q;
    assign bus.idx     = idx_q;
    assign bus.acc_rst = acc_rst_q;
    assign bus.ld      = ld_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
endmodule

// File: tb/tb_neuron_ctrl.sv
// Directed bench for neuron_ctrl: N=4 and N=1 instances, per-cycle vector tables
// plus hand-written sequences for ignored/held start, reset abort and a MAC model.
module tb_neuron_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    neuron_ctrl_if bus4();
    neuron_ctrl_if bus1();

    neuron_ctrl #(.N(4)) dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4));
    neuron_ctrl #(.N(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(bus1));

    typedef struct {
        logic        start;
        logic [15:0] res;
        logic        rd_en;
        logic [15:0] idx;
        logic        acc_rst;
        logic        ld;
        logic        busy;
        logic        done;
        logic [15:0] result;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // MAC datapath model for the N=4 instance: 1-cycle memories, accumulator, ReLU
    logic [15:0] mem_in [4];
    logic [15:0] mem_w  [4];
    logic [15:0] in_q = '0;
    logic [15:0] w_q  = '0;
    logic [15:0] acc  = '0;
    logic [15:0] model_res;
    logic [15:0] stub_res4;
    bit          use_model;

    always @(posedge clk) begin
        if (bus4.rd_en) begin
            in_q <= mem_in[bus4.idx[1:0]];
            w_q  <= mem_w[bus4.idx[1:0]];
        end
        if (bus4.acc_rst)
            acc <= '0;
        else if (bus4.ld)
            acc <= acc + 16'(in_q * w_q);
    end

    assign model_res = acc[15] ? 16'd0 : acc;

    always_comb begin
        bus4.res = use_model ? model_res : stub_res4;
    end

    task automatic chk(input string name, input int cyc, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check cycle k's outputs of the selected instance, then drive its inputs for that cycle
    task automatic apply(input bit sel1, input int k, input vec_t v);
        if (sel1) begin
            chk("n1_rd_en",   k, 16'(bus1.rd_en),   16'(v.rd_en));
            chk("n1_idx",     k, bus1.idx,          v.idx);
            chk("n1_acc_rst", k, 16'(bus1.acc_rst), 16'(v.acc_rst));
            chk("n1_ld",      k, 16'(bus1.ld),      16'(v.ld));
            chk("n1_busy",    k, 16'(bus1.busy),    16'(v.busy));
            chk("n1_done",    k, 16'(bus1.done),    16'(v.done));
            chk("n1_result",  k, bus1.result,       v.result);
            chk("n1_excl",    k, 16'(bus1.acc_rst & bus1.ld), 16'd0);
            bus1.start = v.start;
            bus1.res   = v.res;
        end else begin
            chk("n4_rd_en",   k, 16'(bus4.rd_en),   16'(v.rd_en));
            chk("n4_idx",     k, bus4.idx,          v.idx);
            chk("n4_acc_rst", k, 16'(bus4.acc_rst), 16'(v.acc_rst));
            chk("n4_ld",      k, 16'(bus4.ld),      16'(v.ld));
            chk("n4_busy",    k, 16'(bus4.busy),    16'(v.busy));
            chk("n4_done",    k, 16'(bus4.done),    16'(v.done));
            chk("n4_result",  k, bus4.result,       v.result);
            chk("n4_excl",    k, 16'(bus4.acc_rst & bus4.ld), 16'd0);
            bus4.start = v.start;
            stub_res4  = v.res;
        end
        step();
    endtask

    vec_t v4 [10];
    vec_t v1 [6];

    initial begin
        // start, res, rd_en, idx, acc_rst, ld, busy, done, result
        // starts in cycles 3 and 6 land mid-operation and must be ignored
        v4[0] = '{1'b1, 16'hFFFF, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        v4[1] = '{1'b0, 16'hFFFF, 1'b1, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
        v4[2] = '{1'b0, 16'hFFFF, 1'b1, 16'd1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
        v4[3] = '{1'b1, 16'hFFFF, 1'b1, 16'd2, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
        v4[4] = '{1'b0, 16'hFFFF, 1'b1, 16'd3, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
        v4[5] = '{1'b0, 16'hFFFF, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
        v4[6] = '{1'b1, 16'h1234, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
        v4[7] = '{1'b0, 16'hFFFF, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234};
        v4[8] = '{1'b0, 16'hFFFF, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234};
        v4[9] = '{1'b0, 16'hFFFF, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234};

        v1[0] = '{1'b1, 16'hFFFF, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        v1[1] = '{1'b0, 16'hFFFF, 1'b1, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
        v1[2] = '{1'b0, 16'hFFFF, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
        v1[3] = '{1'b0, 16'h00A5, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000};
        v1[4] = '{1'b0, 16'hFFFF, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h00A5};
        v1[5] = '{1'b0, 16'hFFFF, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00A5};

        mem_in[0] = 16'd3; mem_in[1] = 16'd2; mem_in[2] = 16'd5; mem_in[3] = 16'd1;
        mem_w[0]  = 16'd2; mem_w[1]  = 16'd3; mem_w[2]  = 16'd1; mem_w[3]  = 16'd4;

        use_model  = 1'b0;
        stub_res4  = 16'hFFFF;
        bus4.start = 1'b0;
        bus1.start = 1'b0;
        bus1.res   = 16'hFFFF;
        rst        = 1'b1;
        step();
        step();

        chk("rst_rd_en",   0, 16'(bus4.rd_en),   16'd0);
        chk("rst_idx",     0, bus4.idx,          16'd0);
        chk("rst_acc_rst", 0, 16'(bus4.acc_rst), 16'd0);
        chk("rst_ld",      0, 16'(bus4.ld),      16'd0);
        chk("rst_busy",    0, 16'(bus4.busy),    16'd0);
        chk("rst_done",    0, 16'(bus4.done),    16'd0);
        chk("rst_result",  0, bus4.result,       16'd0);
        chk("rst_n1_busy", 0, 16'(bus1.busy),    16'd0);
        rst = 1'b0;

        // N=4 pulse with stub res, ignored mid-run starts
        for (int k = 0; k < 10; k++) apply(1'b0, k, v4[k]);

        // result holds through idle cycles
        for (int k = 10; k < 20; k++) begin
            chk("hold_result", k, bus4.result, 16'h1234);
            chk("hold_done",   k, 16'(bus4.done), 16'd0);
            step();
        end

        // start held high: back-to-back operations every N+4 cycles
        for (int k = 0; k < 18; k++) begin
            chk("held_done", k, 16'(bus4.done), 16'((k == 7) || (k == 15)));
            chk("held_busy", k, 16'(bus4.busy), 16'(((k >= 1) && (k <= 7)) || ((k >= 9) && (k <= 15))));
            bus4.start = (k <= 15);
            step();
        end
        bus4.start = 1'b0;
        step();

        // real MAC model: 3*2 + 2*3 + 5*1 + 1*4 = 21, positive so ReLU passes it
        use_model  = 1'b1;
        bus4.start = 1'b1;
        step();
        bus4.start = 1'b0;
        for (int k = 1; k < 7; k++) step();
        chk("mac_done",   7, 16'(bus4.done), 16'd1);
        chk("mac_result", 7, bus4.result,    16'd21);
        step();
        use_model = 1'b0;
        step();

        // reset in cycle 4 aborts the run and clears result
        bus4.start = 1'b1;
        step();
        bus4.start = 1'b0;
        for (int k = 1; k < 4; k++) step();
        chk("abort_idx_c4", 4, bus4.idx, 16'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_rd_en",  5, 16'(bus4.rd_en), 16'd0);
        chk("abort_ld",     5, 16'(bus4.ld),    16'd0);
        chk("abort_busy",   5, 16'(bus4.busy),  16'd0);
        chk("abort_result", 5, bus4.result,     16'd0);
        for (int k = 5; k < 11; k++) begin
            chk("abort_no_done", k, 16'(bus4.done), 16'd0);
            chk("abort_idle",    k, 16'(bus4.busy), 16'd0);
            step();
        end

        // fresh start after abort completes normally
        bus4.start = 1'b1;
        step();
        bus4.start = 1'b0;
        chk("restart_acc_rst", 1, 16'(bus4.acc_rst), 16'd1);
        chk("restart_ld",      1, 16'(bus4.ld),      16'd0);
        for (int k = 1; k < 9; k++) begin
            chk("restart_done", k, 16'(bus4.done), 16'(k == 7));
            if (k == 7) chk("restart_result", k, bus4.result, 16'hFFFF);
            step();
        end

        // N=1 corner case
        for (int k = 0; k < 6; k++) apply(1'b1, k, v1[k]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
